// File: rtl/xbar_pipe_pkg.sv
// Shared constants and helpers for the NoC switch-traversal crossbar.
// Port order is N, E, W, S, L; both index and one-hot forms are provided.
package xbar_pipe_pkg;

  localparam int unsigned XBAR_NUM_PORTS  = 5;
  localparam int unsigned XBAR_DATA_WIDTH = 32;

  localparam int unsigned N_PORT = 0;
  localparam int unsigned E_PORT = 1;
  localparam int unsigned W_PORT = 2;
  localparam int unsigned S_PORT = 3;
  localparam int unsigned L_PORT = 4;

  localparam logic [4:0] N_PORT_OH = 5'b00001;
  localparam logic [4:0] E_PORT_OH = 5'b00010;
  localparam logic [4:0] W_PORT_OH = 5'b00100;
  localparam logic [4:0] S_PORT_OH = 5'b01000;
  localparam logic [4:0] L_PORT_OH = 5'b10000;

  // True when at most one bit is set (zero counts as legal, meaning "no input").
  function automatic logic is_onehot0(input logic [31:0] v);
    return ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/xbar_pipe_out_slice.sv
// One crossbar output: AND-OR input mux, select legality check,
// one-entry valid/ready output register and a sticky illegal-select flag.
module xbar_out_slice
  import xbar_pipe_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = XBAR_NUM_PORTS,
  parameter int unsigned DATA_WIDTH = XBAR_DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            i_sel,
  input  logic [NUM_PORTS-1:0]            i_grant,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_data,
  input  logic                            i_ready,
  output logic                            o_load,
  output logic                            o_sel_ok,
  output logic                            o_valid,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic                            o_sel_err
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_sel_err;
  logic                  w_sel_ok;
  logic                  w_load;
  logic                  w_hit;
  logic [DATA_WIDTH-1:0] w_mux;

  assign w_sel_ok = is_onehot0(32'(i_sel));
  assign w_load   = ~r_valid | i_ready;
  // i_grant already folds in valid_in and the multicast all-ready gating.
  assign w_hit    = w_sel_ok & (|(i_sel & i_grant));

  // AND-OR mux over the granted, selected inputs
  always_comb begin
    w_mux = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (i_sel[i] & i_grant[i]) begin
        w_mux = w_mux | i_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        w_mux = w_mux;
      end
    end
  end

  // Output register and sticky illegal-select flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_data    <= {DATA_WIDTH{1'b0}};
      r_sel_err <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid <= w_hit;
        r_data  <= w_hit ? w_mux : {DATA_WIDTH{1'b0}};
      end
      if (!w_sel_ok) begin
        r_sel_err <= 1'b1;
      end
    end
  end

  assign o_load    = w_load;
  assign o_sel_ok  = w_sel_ok;
  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_sel_err = r_sel_err;

endmodule

// File: rtl/xbar_pipe.sv
// Registered NxN crossbar: per-output slices plus the input acknowledge,
// where a multicast flit is taken only when every selecting output can load.
module xbar_pipe
  import xbar_pipe_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = XBAR_NUM_PORTS,
  parameter int unsigned DATA_WIDTH = XBAR_DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*NUM_PORTS-1:0]  sel_in,
  input  logic [NUM_PORTS-1:0]            valid_in,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] datain,
  output logic [NUM_PORTS-1:0]            ack_out,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] dataout,
  output logic [NUM_PORTS-1:0]            valid_out,
  input  logic [NUM_PORTS-1:0]            ready_in,
  output logic [NUM_PORTS-1:0]            sel_err
);

  logic [NUM_PORTS-1:0]           w_load;
  logic [NUM_PORTS-1:0]           w_sel_ok;
  logic [NUM_PORTS-1:0]           w_go;
  logic [NUM_PORTS*NUM_PORTS-1:0] w_req;

  genvar o;
  generate
    for (o = 0; o < NUM_PORTS; o++) begin : g_out
      assign w_req[o*NUM_PORTS +: NUM_PORTS] =
        sel_in[o*NUM_PORTS +: NUM_PORTS] & valid_in & {NUM_PORTS{w_sel_ok[o]}};

      xbar_out_slice #(
        .NUM_PORTS  (NUM_PORTS),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_slice (
        .clk       (clk),
        .rst       (rst),
        .i_sel     (sel_in[o*NUM_PORTS +: NUM_PORTS]),
        .i_grant   (w_go),
        .i_data    (datain),
        .i_ready   (ready_in[o]),
        .o_load    (w_load[o]),
        .o_sel_ok  (w_sel_ok[o]),
        .o_valid   (valid_out[o]),
        .o_data    (dataout[o*DATA_WIDTH +: DATA_WIDTH]),
        .o_sel_err (sel_err[o])
      );
    end
  endgenerate

  // An input goes only if some legal requester can load and none is stalled.
  always_comb begin
    w_go = {NUM_PORTS{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      logic v_any;
      logic v_blk;
      v_any = 1'b0;
      v_blk = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        v_any = v_any | (w_req[k*NUM_PORTS + i] &  w_load[k]);
        v_blk = v_blk | (w_req[k*NUM_PORTS + i] & ~w_load[k]);
      end
      w_go[i] = v_any & ~v_blk & ~rst;
    end
  end

  assign ack_out = w_go;

endmodule

// File: tb/tb_xbar_pipe.sv
// Directed, table-driven bench for xbar_pipe with hand-written multi-cycle
// sequences for reset, backpressure, multicast stall and illegal selects.
module tb_xbar_pipe;

  localparam int NP = 5;
  localparam int DW = 32;

  logic              clk;
  logic              rst;
  logic [NP*NP-1:0]  sel_in;
  logic [NP-1:0]     valid_in;
  logic [NP*DW-1:0]  datain;
  logic [NP-1:0]     ack_out;
  logic [NP*DW-1:0]  dataout;
  logic [NP-1:0]     valid_out;
  logic [NP-1:0]     ready_in;
  logic [NP-1:0]     sel_err;
  logic [DW-1:0]     din [NP];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [NP*NP-1:0] sel;
    logic [NP-1:0]    valid;
    logic [7:0]       base;
    logic [NP-1:0]    ready;
    logic [NP-1:0]    ack;
    logic [NP-1:0]    vout;
    logic [NP*DW-1:0] dout;
  } vec_t;

  vec_t vecs [4];

  xbar_pipe #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .sel_in    (sel_in),
    .valid_in  (valid_in),
    .datain    (datain),
    .ack_out   (ack_out),
    .dataout   (dataout),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .sel_err   (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NP; i++) datain[i*DW +: DW] = din[i];
  end

  function automatic logic [NP*NP-1:0] mk_sel(input logic [4:0] s0, s1, s2, s3, s4);
    return {s4, s3, s2, s1, s0};
  endfunction

  function automatic logic [NP*DW-1:0] mk_dout(input logic [7:0] d0, d1, d2, d3, d4);
    return {24'h0, d4, 24'h0, d3, 24'h0, d2, 24'h0, d1, 24'h0, d0};
  endfunction

  function automatic vec_t mk_vec(input logic [NP*NP-1:0] s, input logic [4:0] v,
                                  input logic [7:0] b, input logic [4:0] r,
                                  input logic [4:0] a, input logic [4:0] vo,
                                  input logic [NP*DW-1:0] d);
    vec_t t;
    t.sel = s; t.valid = v; t.base = b; t.ready = r; t.ack = a; t.vout = vo; t.dout = d;
    return t;
  endfunction

  task automatic check(input string name, input logic [NP*DW-1:0] act, input logic [NP*DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int i = 0; i < NP; i++) din[i] = 32'(base) + 32'(i);
  endtask

  task automatic drive(input logic [NP*NP-1:0] s, input logic [4:0] v, input logic [4:0] r);
    sel_in = s; valid_in = v; ready_in = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] out_word(input int o);
    return dataout[o*DW +: DW];
  endfunction

  initial begin
    vecs[0] = mk_vec(mk_sel(5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001), 5'b11111, 8'hA0,
                     5'b11111, 5'b11111, 5'b11111, mk_dout(8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA0));
    vecs[1] = mk_vec(mk_sel(5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000), 5'b10101, 8'h10,
                     5'b11111, 5'b10101, 5'b10101, mk_dout(8'h10, 8'h00, 8'h12, 8'h00, 8'h14));
    vecs[2] = mk_vec(mk_sel(5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000), 5'b11111, 8'h30,
                     5'b11111, 5'b10000, 5'b11111, mk_dout(8'h34, 8'h34, 8'h34, 8'h34, 8'h34));
    vecs[3] = mk_vec(mk_sel(5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000), 5'b11111, 8'h50,
                     5'b11111, 5'b00000, 5'b00000, mk_dout(8'h00, 8'h00, 8'h00, 8'h00, 8'h00));

    // Reset held for two cycles with everything requesting
    rst = 1'b1;
    set_data(8'hA0);
    drive(vecs[0].sel, 5'b11111, 5'b11111);
    for (int c = 0; c < 2; c++) begin
      step();
      check("rst_valid_out", 160'(valid_out), 160'(5'b00000));
      check("rst_dataout", dataout, 160'h0);
      check("rst_ack", 160'(ack_out), 160'(5'b00000));
      check("rst_sel_err", 160'(sel_err), 160'(5'b00000));
    end
    rst = 1'b0;

    // Table vectors, all outputs ready so each is independent of the last
    for (int k = 0; k < 4; k++) begin
      set_data(vecs[k].base);
      drive(vecs[k].sel, vecs[k].valid, vecs[k].ready);
      #1;
      check($sformatf("vec%0d_ack", k), 160'(ack_out), 160'(vecs[k].ack));
      step();
      check($sformatf("vec%0d_valid", k), 160'(valid_out), 160'(vecs[k].vout));
      check($sformatf("vec%0d_data", k), dataout, vecs[k].dout);
      check($sformatf("vec%0d_err", k), 160'(sel_err), 160'(5'b00000));
    end

    // Backpressure on output 2 fed from L
    din[4] = 32'h55;
    drive(mk_sel(5'b0, 5'b0, 5'b10000, 5'b0, 5'b0), 5'b10000, 5'b11111);
    #1; check("bp_fill_ack", 160'(ack_out), 160'(5'b10000));
    step();
    check("bp_fill_data", 160'(out_word(2)), 160'(32'h55));
    din[4] = 32'h66;
    ready_in = 5'b11011;
    for (int c = 0; c < 3; c++) begin
      #1; check($sformatf("bp_stall%0d_ack", c), 160'(ack_out), 160'(5'b00000));
      step();
      check($sformatf("bp_stall%0d_data", c), 160'(out_word(2)), 160'(32'h55));
      check($sformatf("bp_stall%0d_valid", c), 160'(valid_out[2]), 160'(1'b1));
    end
    ready_in = 5'b11111;
    #1; check("bp_release_ack", 160'(ack_out), 160'(5'b10000));
    step();
    check("bp_release_data", 160'(out_word(2)), 160'(32'h66));

    // Multicast E to outputs 0 and 3 while output 3 is stalled
    din[2] = 32'h33;
    drive(mk_sel(5'b0, 5'b0, 5'b0, 5'b00100, 5'b0), 5'b00100, 5'b11111);
    step();
    check("mc_fill3", 160'(out_word(3)), 160'(32'h33));
    din[1] = 32'h77;
    drive(mk_sel(5'b00010, 5'b0, 5'b0, 5'b00010, 5'b0), 5'b00010, 5'b10111);
    #1; check("mc_stall_ack", 160'(ack_out), 160'(5'b00000));
    step();
    check("mc_stall_valid", 160'(valid_out), 160'(5'b01000));
    check("mc_stall_data3", 160'(out_word(3)), 160'(32'h33));
    check("mc_stall_data0", 160'(out_word(0)), 160'(32'h0));
    ready_in = 5'b11111;
    #1; check("mc_go_ack", 160'(ack_out), 160'(5'b00010));
    step();
    check("mc_go_valid", 160'(valid_out), 160'(5'b01001));
    check("mc_go_data0", 160'(out_word(0)), 160'(32'h77));
    check("mc_go_data3", 160'(out_word(3)), 160'(32'h77));

    // Illegal select on output 1; output 2 legally takes W
    din[1] = 32'hE1;
    din[2] = 32'hB2;
    drive(mk_sel(5'b0, 5'b00110, 5'b00100, 5'b0, 5'b0), 5'b00110, 5'b11111);
    #1; check("ill_ack", 160'(ack_out), 160'(5'b00100));
    step();
    check("ill_valid", 160'(valid_out), 160'(5'b00100));
    check("ill_data2", 160'(out_word(2)), 160'(32'hB2));
    check("ill_data1", 160'(out_word(1)), 160'(32'h0));
    check("ill_err", 160'(sel_err), 160'(5'b00010));
    drive(mk_sel(5'b0, 5'b0, 5'b0, 5'b0, 5'b0), 5'b00000, 5'b11111);
    for (int c = 0; c < 2; c++) begin
      step();
      check($sformatf("ill_sticky%0d", c), 160'(sel_err), 160'(5'b00010));
    end

    // Empty select with load flushes output 4
    din[0] = 32'h12;
    drive(mk_sel(5'b0, 5'b0, 5'b0, 5'b0, 5'b00001), 5'b00001, 5'b11111);
    step();
    check("empty_fill", 160'(out_word(4)), 160'(32'h12));
    check("empty_fill_valid", 160'(valid_out[4]), 160'(1'b1));
    drive(mk_sel(5'b0, 5'b0, 5'b0, 5'b0, 5'b0), 5'b00000, 5'b11111);
    step();
    check("empty_valid", 160'(valid_out), 160'(5'b00000));
    check("empty_data", dataout, 160'h0);

    // Reset mid-stall: output 2 held, reset drops it and clears sel_err
    din[4] = 32'h99;
    drive(mk_sel(5'b0, 5'b11000, 5'b10000, 5'b0, 5'b0), 5'b10000, 5'b11111);
    step();
    check("rst2_err_set", 160'(sel_err), 160'(5'b00010));
    ready_in = 5'b11011;
    rst = 1'b1;
    #1; check("rst2_ack", 160'(ack_out), 160'(5'b00000));
    step();
    check("rst2_valid", 160'(valid_out), 160'(5'b00000));
    check("rst2_data", dataout, 160'h0);
    check("rst2_err", 160'(sel_err), 160'(5'b00000));
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xbar_pipe.md
# xbar_pipe

Parametrised, registered NxN crossbar for the NoC router. Each of `NUM_PORTS` outputs has its own one-hot select from the arbiter and a one-entry output register with valid/ready flow control, so the switch traversal stage is a clean pipeline stage that stalls per output. Inputs receive a same-cycle acknowledge when their flit is captured. Illegal (non-one-hot) selects are blocked and reported through a sticky error flag. The block sits between the per-input FIFOs/arbiters and the output link registers.

## Interface
- `NUM_PORTS`, 5, number of input and output ports; index 0..4 = N, E, W, S, L.
- `DATA_WIDTH`, 32, flit width in bits.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sel_in`  in  NUM_PORTS*NUM_PORTS  per-output one-hot input select; slice [o*NUM_PORTS +: NUM_PORTS] is for output o; bit i selects input i.
- `valid_in`  in  NUM_PORTS  input i presents a flit.
- `datain`  in  NUM_PORTS*DATA_WIDTH  input i flit at [i*DATA_WIDTH +: DATA_WIDTH].
- `ack_out`  out  NUM_PORTS  combinational; input i's flit is captured this edge.
- `dataout`  out  NUM_PORTS*DATA_WIDTH  registered output flits, same packing as `datain`.
- `valid_out`  out  NUM_PORTS  registered; output o holds a valid flit.
- `ready_in`  in  NUM_PORTS  downstream of output o accepts this cycle.
- `sel_err`  out  NUM_PORTS  sticky; output o has seen a select with more than one bit set.

## Operation
- Per output o: `load[o] = !valid_out[o] | ready_in[o]`.
- `sel_ok[o]` = select slice is zero or exactly one-hot. `hit[o]` = `sel_ok[o]` and the selected input has `valid_in` set.
- On the clock edge when `load[o]`:
  - `valid_out[o] <= hit[o]`.
  - `dataout[o] <= hit[o] ? datain[sel] : 0`.
- When `!load[o]`, the output register holds, and `valid_out[o]` and `dataout[o]` are stable.
- `ack_out[i]` = OR over o of (`sel[o][i] & sel_ok[o] & valid_in[i] & load[o]`).
- If two outputs select the same input in one cycle, the flit is copied to both (multicast). `ack_out[i]` is asserted only if every selecting output has `load` set. Otherwise neither output captures it: the captures for input i are gated by the same all-ready term.
- Non-one-hot select: the output treats it as an empty select (loads valid 0 / data 0 if `load`) and sets `sel_err[o]`. `sel_err[o]` clears only on `rst`.
- Upstream must hold `datain`/`valid_in` until `ack_out` is asserted. The block does not buffer unacknowledged flits.

## Timing
- Reset: `valid_out`=0, `dataout`=0, `sel_err`=0. `ack_out` is 0 during reset cycles because captures are suppressed while `rst`=1.
- Latency is 1 cycle from input capture (ack edge) to `valid_out`.
- Throughput is 1 flit/cycle/output while `ready_in` stays high (pass-through of `ready_in` into `load`).
- A `valid_out` & `ready_in` handshake and a new capture occur on the same edge. No bubble is inserted.
- `ack_out` has a combinational path from `ready_in`, `sel_in` and `valid_in`. Upstream registers it only at its own FIFO pop.
- Reset asserted mid-stall drops held flits. No flit is acknowledged in the reset cycle.

## Structure
- Port index constants (`N_PORT`..`L_PORT` as indices 0..4) and `DATA_WIDTH` live in the shared parameters include. The state defines include gains index-form port constants alongside the existing one-hot forms.
- Sub-module `xbar_out_slice` covers one output: a NUM_PORTS:1 AND-OR mux, the one-hot check, the output register, and `sel_err`.
- The top level instantiates `NUM_PORTS` slices in a generate loop and forms `ack_out` plus the multicast all-ready gating.

## Test plan
- Reset then idle: hold `rst`=1 for 2 cycles with `valid_in`=5'b11111 and all selects driven. Required: `valid_out`=0, `dataout`=0, `ack_out`=0 throughout. After release, the first capture appears on the next edge.
- Full permutation: output o selects input (o+1)%5, every input is valid with data 0xA0+i, and `ready_in`=all 1. Required: `ack_out`=5'b11111. One cycle later, output 0 holds 0xA1 and output 4 holds 0xA0, with all `valid_out` set.
- Backpressure: fill output 2 from L (data 0x55) and drop `ready_in[2]` for 3 cycles with a new L flit 0x66 pending. Required: `dataout[2]`=0x55 is stable, and `ack_out[L]`=0 for 3 cycles. On the cycle `ready_in[2]` rises, 0x66 is acked and appears on the next edge.
- Multicast with partial stall: outputs 0 and 3 both select input E (0x77). Output 3 is full with `ready_in[3]`=0. Required: `ack_out[E]`=0 and output 0 does not load 0x77. Once `ready_in[3]`=1, both outputs capture 0x77 on the same edge.
- Illegal select: output 1 select = 5'b00110 with `ready_in[1]`=1. Required: `valid_out[1]` is 0 next cycle, `ack_out` bits for E and W come only from other outputs, and `sel_err[1]`=1 stays set until `rst`.
- Empty select with `load`: output 4 holding 0x12, `ready_in[4]`=1, select 0. Required: `valid_out[4]`=0 and `dataout[4]`=0 next cycle.
